// File: rtl/fp_gpio_ctrl_pkg.sv
// Shared constants for the front-panel GPIO controller: default pin masks,
// synchronizer depth bounds and the irq_status bit layout seen by software.
package fp_gpio_ctrl_pkg;

    localparam int GPIO_REG_WIDTH_DEF = 12;

    localparam logic [GPIO_REG_WIDTH_DEF-1:0] OUT_MASK_DEF = 12'h011;
    localparam logic [GPIO_REG_WIDTH_DEF-1:0] IN_MASK_DEF  = 12'h044;
    localparam logic [GPIO_REG_WIDTH_DEF-1:0] DDR_MASK_DEF = 12'h011;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // irq_status is one flag per pin; only input-capable pins can ever set
    localparam int IRQ_STATUS_LSB = 0;
    localparam int IRQ_STATUS_MSB = GPIO_REG_WIDTH_DEF - 1;
    localparam int IRQ_BIT_FP2    = 2;
    localparam int IRQ_BIT_FP6    = 6;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_e;

    function automatic int clamp_sync_stages(input int stages);
        if (stages < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
        if (stages > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
        return stages;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin's input path: synchronizer chain followed by a length-N debounce
// that accepts a new level only after it has been seen for N+1 cycles.
module gpio_debounce
    import fp_gpio_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pad_in,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    output logic                  s,
    output logic                  stable,
    output logic                  update
);

    // Out-of-range depths are pulled into the supported window
    localparam int STAGES = clamp_sync_stages(SYNC_STAGES);

    logic sync_chain [STAGES+1];

    assign sync_chain[0] = pad_in;

    for (genvar i = 0; i < STAGES; i++) begin : g_sync
        regN_ff #(.WIDTH(1)) u_sync_ff (
            .clk   (clk),
            .reset (reset),
            .d     (sync_chain[i]),
            .q     (sync_chain[i+1])
        );
    end

    assign s = sync_chain[STAGES];

    logic                  stable_q, stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        update   = 1'b0;
        if (s != stable_q) begin
            if (cnt_q == debounce_len) begin
                stable_d = s;
                update   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/regN_ff.sv
// Generic N-bit register with synchronous active-high reset.
module regN_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else       q <= d;
    end

endmodule

// File: rtl/fp_gpio_ctrl.sv
// Front-panel GPIO controller top: masked registered pad outputs, per-pin
// debounced inputs, and sticky write-1-to-clear edge interrupt status.
module fp_gpio_ctrl
    import fp_gpio_ctrl_pkg::*;
#(
    parameter int                        GPIO_REG_WIDTH = GPIO_REG_WIDTH_DEF,
    parameter int                        SYNC_STAGES    = 2,
    parameter int                        DEBOUNCE_W     = 8,
    parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = OUT_MASK_DEF,
    parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK        = IN_MASK_DEF,
    parameter logic [GPIO_REG_WIDTH-1:0] DDR_MASK       = DDR_MASK_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_out,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_ddr,
    input  logic [DEBOUNCE_W-1:0]     debounce_len,
    input  logic [GPIO_REG_WIDTH-1:0] rise_en,
    input  logic [GPIO_REG_WIDTH-1:0] fall_en,
    input  logic [GPIO_REG_WIDTH-1:0] irq_clr,
    output logic [GPIO_REG_WIDTH-1:0] gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] irq_status,
    output logic                      irq
);

    logic [GPIO_REG_WIDTH-1:0] s_vec;
    logic [GPIO_REG_WIDTH-1:0] stable_vec;
    logic [GPIO_REG_WIDTH-1:0] update_vec;

    for (genvar p = 0; p < GPIO_REG_WIDTH; p++) begin : g_pin
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_W  (DEBOUNCE_W)
        ) u_debounce (
            .clk          (clk),
            .reset        (reset),
            .pad_in       (fp_gpio_in[p]),
            .debounce_len (debounce_len),
            .s            (s_vec[p]),
            .stable       (stable_vec[p]),
            .update       (update_vec[p])
        );
    end

    logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr_q, fp_gpio_ddr_d;
    logic [GPIO_REG_WIDTH-1:0] fp_gpio_out_q, fp_gpio_out_d;
    logic [GPIO_REG_WIDTH-1:0] irq_status_q, irq_status_d;
    logic [GPIO_REG_WIDTH-1:0] rise, fall;

    // A pin only drives high when it is both allowed and requested as output
    always_comb begin
        fp_gpio_ddr_d = gpio_ddr & DDR_MASK;
        fp_gpio_out_d = gpio_out & OUT_MASK & gpio_ddr & DDR_MASK;
        rise          = update_vec &  s_vec & rise_en & IN_MASK;
        fall          = update_vec & ~s_vec & fall_en & IN_MASK;
        irq_status_d  = (irq_status_q & ~irq_clr) | rise | fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fp_gpio_ddr_q <= '0;
            fp_gpio_out_q <= '0;
            irq_status_q  <= '0;
        end else begin
            fp_gpio_ddr_q <= fp_gpio_ddr_d;
            fp_gpio_out_q <= fp_gpio_out_d;
            irq_status_q  <= irq_status_d;
        end
    end

    assign fp_gpio_ddr = fp_gpio_ddr_q;
    assign fp_gpio_out = fp_gpio_out_q;
    assign gpio_in     = stable_vec & IN_MASK;
    assign irq_status  = irq_status_q;
    assign irq         = |irq_status_q;

endmodule

// File: tb/tb_fp_gpio_ctrl.sv
// Scoreboard bench for fp_gpio_ctrl: stimulus queues cycle-stamped expected
// outputs, and a negedge monitor compares them when their cycle comes up.
module tb_fp_gpio_ctrl;

    localparam int W = 12;

    localparam int SEL_GPIO_IN = 0;
    localparam int SEL_STATUS  = 1;
    localparam int SEL_IRQ     = 2;
    localparam int SEL_OUT     = 3;
    localparam int SEL_DDR     = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  fp_gpio_in;
    logic [W-1:0]  fp_gpio_out;
    logic [W-1:0]  fp_gpio_ddr;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_ddr;
    logic [7:0]    debounce_len;
    logic [W-1:0]  rise_en;
    logic [W-1:0]  fall_en;
    logic [W-1:0]  irq_clr;
    logic [W-1:0]  gpio_in;
    logic [W-1:0]  irq_status;
    logic          irq;

    fp_gpio_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .fp_gpio_in   (fp_gpio_in),
        .fp_gpio_out  (fp_gpio_out),
        .fp_gpio_ddr  (fp_gpio_ddr),
        .gpio_out     (gpio_out),
        .gpio_ddr     (gpio_ddr),
        .debounce_len (debounce_len),
        .rise_en      (rise_en),
        .fall_en      (fall_en),
        .irq_clr      (irq_clr),
        .gpio_in      (gpio_in),
        .irq_status   (irq_status),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int           due;
        string        name;
        int           sel;
        logic [W-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_expect(input int offset, input string name, input int sel, input logic [W-1:0] val);
        exp_t e;
        int   idx;
        e.due  = cyc + offset;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > e.due) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic applyStimulus(input logic [W-1:0] pads, input logic [W-1:0] ren, input logic [W-1:0] fen);
        fp_gpio_in = pads;
        rise_en    = ren;
        fall_en    = fen;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [W-1:0] act;
        case (e.sel)
            SEL_GPIO_IN: act = gpio_in;
            SEL_STATUS:  act = irq_status;
            SEL_IRQ:     act = {{(W-1){1'b0}}, irq};
            SEL_OUT:     act = fp_gpio_out;
            default:     act = fp_gpio_ddr;
        endcase
        total++;
        if (act !== e.val) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got 'h%03h expected 'h%03h", e.name, cyc, act, e.val);
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        reset        = 1'b1;
        fp_gpio_in   = '0;
        gpio_out     = '0;
        gpio_ddr     = '0;
        debounce_len = 8'd0;
        rise_en      = '0;
        fall_en      = '0;
        irq_clr      = '0;

        tick(3);
        push_expect(0, "rst_gpio_in", SEL_GPIO_IN, 12'h000);
        push_expect(0, "rst_status",  SEL_STATUS,  12'h000);
        push_expect(0, "rst_irq",     SEL_IRQ,     12'h000);
        push_expect(0, "rst_out",     SEL_OUT,     12'h000);
        push_expect(0, "rst_ddr",     SEL_DDR,     12'h000);
        reset = 1'b0;
        tick(1);

        // Output masking
        gpio_ddr = 12'hFFF;
        gpio_out = 12'hFFF;
        push_expect(1, "ddr_masked", SEL_DDR, 12'h011);
        push_expect(1, "out_masked", SEL_OUT, 12'h011);
        tick(2);
        gpio_ddr = 12'h000;
        push_expect(1, "out_not_output", SEL_OUT, 12'h000);
        push_expect(1, "ddr_cleared",    SEL_DDR, 12'h000);
        tick(2);

        // N=0 rise on pin 2: visible after SYNC_STAGES+N+1 = 3 cycles
        applyStimulus(12'h004, 12'h004, 12'h000);
        push_expect(2, "n0_before",   SEL_GPIO_IN, 12'h000);
        push_expect(3, "n0_gpio_in",  SEL_GPIO_IN, 12'h004);
        push_expect(3, "n0_status",   SEL_STATUS,  12'h004);
        push_expect(3, "n0_irq",      SEL_IRQ,     12'h001);
        tick(5);
        applyStimulus(12'h000, 12'h004, 12'h000);
        push_expect(3, "n0_fall_in",     SEL_GPIO_IN, 12'h000);
        push_expect(3, "n0_fall_nostat", SEL_STATUS,  12'h004);
        tick(4);

        // Clear and set on the same bit in the same cycle: set wins
        applyStimulus(12'h004, 12'h004, 12'h000);
        tick(2);
        irq_clr = 12'h004;
        push_expect(1, "clr_vs_set_status", SEL_STATUS,  12'h004);
        push_expect(1, "clr_vs_set_in",     SEL_GPIO_IN, 12'h004);
        tick(1);
        irq_clr = 12'h000;
        tick(2);
        irq_clr = 12'h004;
        push_expect(1, "clr_status", SEL_STATUS, 12'h000);
        push_expect(1, "clr_irq",    SEL_IRQ,    12'h000);
        tick(1);
        irq_clr = 12'h000;
        tick(2);

        // N=5: 5-cycle glitch rejected
        debounce_len = 8'd5;
        applyStimulus(12'h044, 12'h044, 12'h000);
        tick(5);
        applyStimulus(12'h004, 12'h044, 12'h000);
        push_expect(6, "glitch_gpio_in", SEL_GPIO_IN, 12'h004);
        push_expect(6, "glitch_status",  SEL_STATUS,  12'h000);
        tick(10);

        // N=5: 6-cycle pulse accepted at 2+5+1 = 8, then falls 8 after release
        applyStimulus(12'h044, 12'h044, 12'h000);
        push_expect(7, "pulse_before",  SEL_GPIO_IN, 12'h004);
        push_expect(8, "pulse_gpio_in", SEL_GPIO_IN, 12'h044);
        push_expect(8, "pulse_status",  SEL_STATUS,  12'h040);
        push_expect(8, "pulse_irq",     SEL_IRQ,     12'h001);
        tick(6);
        applyStimulus(12'h004, 12'h044, 12'h000);
        push_expect(7, "pulse_hold",    SEL_GPIO_IN, 12'h044);
        push_expect(8, "pulse_release", SEL_GPIO_IN, 12'h004);
        push_expect(8, "pulse_nofall",  SEL_STATUS,  12'h040);
        tick(10);
        irq_clr = 12'h040;
        push_expect(1, "clr6_status", SEL_STATUS, 12'h000);
        tick(1);
        irq_clr = 12'h000;
        tick(1);

        // Falling-edge capture only on pin 6
        applyStimulus(12'h044, 12'h000, 12'h040);
        push_expect(8, "fall_rise_in",     SEL_GPIO_IN, 12'h044);
        push_expect(8, "fall_rise_nostat", SEL_STATUS,  12'h000);
        tick(10);
        applyStimulus(12'h004, 12'h000, 12'h040);
        push_expect(8, "fall_gpio_in", SEL_GPIO_IN, 12'h004);
        push_expect(8, "fall_status",  SEL_STATUS,  12'h040);
        push_expect(8, "fall_irq",     SEL_IRQ,     12'h001);
        tick(10);

        // Pin 0 is not an input pin: no visibility, no status
        applyStimulus(12'h005, 12'hFFF, 12'hFFF);
        push_expect(8, "pin0_hi_in",     SEL_GPIO_IN, 12'h004);
        push_expect(8, "pin0_hi_status", SEL_STATUS,  12'h040);
        tick(10);
        applyStimulus(12'h004, 12'hFFF, 12'hFFF);
        push_expect(8, "pin0_lo_in",     SEL_GPIO_IN, 12'h004);
        push_expect(8, "pin0_lo_status", SEL_STATUS,  12'h040);
        tick(10);

        // Pin held high through reset, N=3: rises 6 cycles after release
        applyStimulus(12'h004, 12'h004, 12'h004);
        debounce_len = 8'd3;
        gpio_ddr = 12'h011;
        gpio_out = 12'h011;
        push_expect(1, "pre_rst_out", SEL_OUT, 12'h011);
        tick(2);
        reset = 1'b1;
        push_expect(1, "rst2_out",     SEL_OUT,     12'h000);
        push_expect(1, "rst2_ddr",     SEL_DDR,     12'h000);
        push_expect(1, "rst2_status",  SEL_STATUS,  12'h000);
        push_expect(1, "rst2_gpio_in", SEL_GPIO_IN, 12'h000);
        push_expect(1, "rst2_irq",     SEL_IRQ,     12'h000);
        tick(3);
        reset = 1'b0;
        push_expect(5, "post_rst_before", SEL_GPIO_IN, 12'h000);
        push_expect(6, "post_rst_in",     SEL_GPIO_IN, 12'h004);
        push_expect(6, "post_rst_status", SEL_STATUS,  12'h004);
        push_expect(6, "post_rst_irq",    SEL_IRQ,     12'h001);
        tick(8);

        // Reset in the middle of a falling count discards it
        applyStimulus(12'h000, 12'h004, 12'h004);
        tick(3);
        reset = 1'b1;
        push_expect(1, "midrst_gpio_in", SEL_GPIO_IN, 12'h000);
        push_expect(1, "midrst_status",  SEL_STATUS,  12'h000);
        push_expect(1, "midrst_irq",     SEL_IRQ,     12'h000);
        push_expect(1, "midrst_out",     SEL_OUT,     12'h000);
        tick(2);
        reset = 1'b0;
        push_expect(10, "midrst_no_edge", SEL_STATUS,  12'h000);
        push_expect(10, "midrst_quiet",   SEL_GPIO_IN, 12'h000);
        tick(12);

        tick(3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("[TB] FAIL %s never checked: due cycle %0d, now %0d", e.name, e.due, cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_gpio_ctrl.md
# fp_gpio_ctrl

Front-panel GPIO controller, successor to the fixed-mask GPIO block. Adds runtime per-pin direction, a configurable-depth input synchronizer, a per-pin debounce counter, and per-pin rising/falling edge capture into a sticky, write-1-to-clear interrupt status with a summary interrupt. It sits between the front-panel pad ring and the user settings/readback registers, in the single radio clock domain.

## Interface
- GPIO_REG_WIDTH, 12: number of front-panel pins.
- SYNC_STAGES, 2: input synchronizer depth; legal range 2..4.
- DEBOUNCE_W, 8: width of the debounce length and counters.
- OUT_MASK, 12'h011: pins allowed to drive; other pins are never driven high.
- IN_MASK, 12'h044: pins visible on gpio_in and eligible for edge capture.
- DDR_MASK, 12'h011: pins allowed to become outputs.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- fp_gpio_in  in  GPIO_REG_WIDTH  raw pad inputs, asynchronous.
- fp_gpio_out  out  GPIO_REG_WIDTH  pad output values.
- fp_gpio_ddr  out  GPIO_REG_WIDTH  pad direction; 1 = output.
- gpio_out  in  GPIO_REG_WIDTH  requested output values.
- gpio_ddr  in  GPIO_REG_WIDTH  requested direction.
- debounce_len  in  DEBOUNCE_W  debounce length N, shared by all pins; static during operation.
- rise_en  in  GPIO_REG_WIDTH  per-pin rising-edge capture enable.
- fall_en  in  GPIO_REG_WIDTH  per-pin falling-edge capture enable.
- irq_clr  in  GPIO_REG_WIDTH  one-cycle write-1-to-clear strobe for irq_status.
- gpio_in  out  GPIO_REG_WIDTH  debounced input state, masked by IN_MASK.
- irq_status  out  GPIO_REG_WIDTH  sticky edge flags.
- irq  out  1  OR-reduction of irq_status.

## Operation
- **Outputs:** both are registered.
  - fp_gpio_ddr <= gpio_ddr & DDR_MASK.
  - fp_gpio_out <= gpio_out & OUT_MASK & gpio_ddr & DDR_MASK.
  - A pin that is not an output always drives 0.
- **Synchronizer:** each pin passes through a SYNC_STAGES flop chain; its output is s.
- **Debounce (per pin):** state is stable (1 bit) and cnt (DEBOUNCE_W bits).
  - If s == stable: cnt <= 0.
  - Else if cnt == debounce_len: stable <= s, cnt <= 0, and the pin's update strobe is asserted this cycle.
  - Else: cnt <= cnt + 1.
  - cnt never exceeds debounce_len, so it cannot wrap.
  - N = 0 accepts any change after one mismatching cycle.
  - A pulse on s shorter than N+1 cycles is rejected and stable is unchanged.
- **gpio_in:** gpio_in = stable & IN_MASK.
- **Edge capture:**
  - rise = update & s & rise_en & IN_MASK.
  - fall = update & ~s & fall_en & IN_MASK.
  - irq_status <= (irq_status & ~irq_clr) | rise | fall.
  - If a clear and a set hit the same bit in the same cycle, the set wins.
- **irq:** combinational OR of irq_status.
- **Reset:** every flop clears to 0, including the sync chain, stable, cnt, irq_status, fp_gpio_out and fp_gpio_ddr. A pin held high through reset therefore produces one rising edge once it has been debounced after reset.

## Timing
- gpio_ddr/gpio_out to pad: 1 cycle.
- Pad change, held steady, to gpio_in: SYNC_STAGES + N + 1 cycles, counted from the first clk edge that samples the new value.
- The irq_status bit sets on the same clk edge that gpio_in changes. irq follows in the same cycle.
- irq_clr takes effect on the next clk edge. irq drops that cycle if no other bits are set.
- A reset asserted mid-debounce discards cnt; no edge is reported for the interrupted change.
- A debounce_len change while a count is in progress is not supported. Software changes it only when inputs are quiet.

## Structure
- Shared package/header holds:
  - the default masks;
  - the SYNC_STAGES legal bounds;
  - the irq_status bit layout constants used by the register map.
- Sub-module gpio_debounce holds one pin's sync chain, stable, cnt and update strobe, parametrised by SYNC_STAGES and DEBOUNCE_W. It is instantiated GPIO_REG_WIDTH times in a generate loop.
- The sync stages reuse regN_ff.
- The top level holds output registers, edge logic, irq_status and irq.

## Test plan
- Reset, then gpio_ddr=12'hFFF, gpio_out=12'hFFF -> one cycle later fp_gpio_ddr=12'h011, fp_gpio_out=12'h011. With gpio_ddr=0 -> fp_gpio_out=0.
- N=0, SYNC_STAGES=2, rise_en[2]=1, pin 2 driven 0->1 -> gpio_in=12'h004 exactly 3 cycles later, irq_status[2]=1 and irq=1 the same cycle.
- N=5: a 5-cycle high glitch on pin 6 -> gpio_in and irq_status unchanged. A 6-cycle high pulse -> gpio_in[6]=1 at cycle 2+5+1=8.
- fall_en[6]=1, rise_en[6]=0, pin 6 1->0 -> irq_status=12'h040. Pin 0 toggled (not in IN_MASK) -> no status, gpio_in[0]=0.
- irq_clr[2] pulsed in the same cycle a new rise on pin 2 is accepted -> irq_status[2] stays 1. irq_clr[2] alone -> bit clears next cycle and irq=0.
- Pin held high while reset deasserts, N=3 -> gpio_in[2] rises at cycle 6 after reset release with irq_status[2]=1. Reset asserted mid-count -> all outputs 0 next cycle.
